receptor_ctrl: RTL and testbench

Sequencing controller that sits between the UART receiver and the consuming logic. It detects each completed receive (rdrf), captures data and framing status, and returns the rdrf_clr handshake to the receiver. Captured bytes go into a small FIFO drained over a valid/ready interface. It also owns the receiver's parity configuration, tracks overrun conditions and counts framing errors.

---
 rtl/receptor_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_receptor_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_ctrl.sv
// UART receive sequencer: captures bytes and framing status, handshakes rdrf_clr, buffers into a FWFT FIFO.
// Define RECEPTOR_CTRL_FE_DROP_EN to discard framing-error bytes instead of queueing them.
module receptor_ctrl #(
    parameter int DATA_LENGHT = 8,
    parameter int FIFO_DEPTH  = 4,
    parameter int CLR_PULSE   = 2,
    parameter int CLR_TIMEOUT = 15
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [DATA_LENGHT-1:0]        rx_data,
    input  logic                          rdrf,
    input  logic                          FE,
    output logic                          rdrf_clr,
    output logic [1:0]                    rx_parity,
    input  logic                          cfg_we,
    input  logic [1:0]                    cfg_parity,
    output logic [DATA_LENGHT-1:0]        out_data,
    output logic                          out_fe,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    output logic                          clr_err,
    input  logic                          err_clr,
    output logic [7:0]                    fe_count
);

`ifdef RECEPTOR_CTRL_FE_DROP_EN
    localparam bit FE_DROP = 1'b1;
`else
    localparam bit FE_DROP = 1'b0;
`endif

    localparam int AW      = $clog2(FIFO_DEPTH);
    localparam int CW      = AW + 1;
    localparam int CNT_MAX = (CLR_TIMEOUT > CLR_PULSE) ? CLR_TIMEOUT : CLR_PULSE;
    localparam int TW      = $clog2(CNT_MAX + 1);
    localparam int EW      = DATA_LENGHT + 1;

    localparam logic [TW-1:0] PULSE_LAST   = TW'(CLR_PULSE - 1);
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(CLR_TIMEOUT - 1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        CAPTURE  = 2'd1,
        CLEAR    = 2'd2,
        WAIT_LOW = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [TW-1:0]   tmr_q, tmr_d;
    logic            capture;
    logic            timeout;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            tmr_q   <= '0;
        end else begin
            state_q <= state_d;
            tmr_q   <= tmr_d;
        end
    end

    // One timer serves both the clear pulse length and the rdrf-low timeout.
    always_comb begin
        state_d = state_q;
        tmr_d   = tmr_q;
        capture = 1'b0;
        timeout = 1'b0;
        case (state_q)
            IDLE: begin
                if (rdrf) state_d = CAPTURE;
            end
            CAPTURE: begin
                capture = 1'b1;
                tmr_d   = '0;
                state_d = CLEAR;
            end
            CLEAR: begin
                if (tmr_q == PULSE_LAST) begin
                    tmr_d   = '0;
                    state_d = WAIT_LOW;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            WAIT_LOW: begin
                if (!rdrf) begin
                    state_d = IDLE;
                end else if (tmr_q == TIMEOUT_LAST) begin
                    timeout = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign rdrf_clr = (state_q == CLEAR);

    logic [EW-1:0]  mem_q [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]  count_q, count_d, remain;
    logic [EW-1:0]  head_q, head_d, entry;
    logic           pop, fits, keep, push, drop, fe_inc;

    assign entry  = {FE, rx_data};
    assign pop    = (count_q != '0) && out_ready;
    assign fits   = (count_q != DEPTH_C) || pop;
    assign keep   = capture && !(FE_DROP && FE);
    assign push   = keep && fits;
    assign drop   = keep && !fits;
    assign fe_inc = capture && FE && (FE_DROP || fits);
    assign remain = count_q - CW'(pop);

    // The head register is reloaded every cycle so out_data stays a flop output.
    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        count_d  = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
        if (remain == '0) head_d = entry;
        else              head_d = mem_q[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry;
        head_q <= head_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign out_valid  = (count_q != '0);
    assign out_data   = head_q[DATA_LENGHT-1:0];
    assign out_fe     = FE_DROP ? 1'b0 : head_q[DATA_LENGHT];
    assign fifo_count = count_q;

    logic       overrun_q, clr_err_q;
    logic [7:0] fe_count_q;

    // Set events take priority over err_clr arriving in the same cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            overrun_q  <= 1'b0;
            clr_err_q  <= 1'b0;
            fe_count_q <= '0;
        end else begin
            if (drop)         overrun_q <= 1'b1;
            else if (err_clr) overrun_q <= 1'b0;
            if (timeout)      clr_err_q <= 1'b1;
            else if (err_clr) clr_err_q <= 1'b0;
            if (fe_inc && (fe_count_q != 8'hFF)) fe_count_q <= fe_count_q + 1'b1;
        end
    end

    assign overrun  = overrun_q;
    assign clr_err  = clr_err_q;
    assign fe_count = fe_count_q;

    logic [1:0] pend_q, pend_d, parity_q, parity_d;
    logic       pend_vld_q, pend_vld_d;

    // Parity only changes between frames so the receiver never switches mid-byte.
    always_comb begin
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        parity_d   = parity_q;
        if ((state_q == IDLE) && !rdrf && (cfg_we || pend_vld_q)) begin
            parity_d   = cfg_we ? cfg_parity : pend_q;
            pend_vld_d = 1'b0;
        end else if (cfg_we) begin
            pend_d     = cfg_parity;
            pend_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q     <= 2'b00;
            pend_vld_q <= 1'b0;
            parity_q   <= 2'b00;
        end else begin
            pend_q     <= pend_d;
            pend_vld_q <= pend_vld_d;
            parity_q   <= parity_d;
        end
    end

    assign rx_parity = parity_q;

endmodule

// File: tb/tb_receptor_ctrl.sv
// Scoreboard bench for receptor_ctrl: stimulus queues expected bytes, a negedge monitor checks every pop.
module tb_receptor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] rx_data;
    logic       rdrf;
    logic       FE;
    logic       rdrf_clr;
    logic [1:0] rx_parity;
    logic       cfg_we;
    logic [1:0] cfg_parity;
    logic [7:0] out_data;
    logic       out_fe;
    logic       out_valid;
    logic       out_ready;
    logic [2:0] fifo_count;
    logic       overrun;
    logic       clr_err;
    logic       err_clr;
    logic [7:0] fe_count;

    int checks = 0;
    int passes = 0;
    logic [8:0] expQ [$];

    always #5 clk = ~clk;

    receptor_ctrl dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rdrf(rdrf), .FE(FE),
        .rdrf_clr(rdrf_clr), .rx_parity(rx_parity), .cfg_we(cfg_we), .cfg_parity(cfg_parity),
        .out_data(out_data), .out_fe(out_fe), .out_valid(out_valid), .out_ready(out_ready),
        .fifo_count(fifo_count), .overrun(overrun), .clr_err(clr_err), .err_clr(err_clr),
        .fe_count(fe_count)
    );

    function automatic void checkOutput(input string name, input logic [31:0] actual,
                                        input logic [31:0] expected);
        checks++;
        if (actual === expected) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    endfunction

    // Monitor: every accepted head is compared against the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
                checkOutput("unexpected_pop", 32'({out_fe, out_data}), 32'h1FF);
            end else begin
                logic [8:0] e;
                e = expQ.pop_front();
                checkOutput("pop_data", 32'(out_data), 32'(e[7:0]));
                checkOutput("pop_fe", 32'(out_fe), 32'(e[8]));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] d, input logic f, input bit stored,
                                 input bit popInCapture, output int pulseLen);
        int k;
        @(posedge clk); #1;
        rx_data = d; FE = f; rdrf = 1'b1;
        if (stored) expQ.push_back({f, d});
        @(posedge clk); #1;
        if (popInCapture) out_ready = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            out_ready = 1'b0;
            k++;
        end while (!rdrf_clr && k < 10);
        pulseLen = 0;
        if (!rdrf_clr) begin
            checkOutput("clr_seen", 32'(rdrf_clr), 1);
        end else begin
            rdrf = 1'b0;
            pulseLen = 1;
            k = 0;
            forever begin
                @(posedge clk); #1;
                k++;
                if (!rdrf_clr || k > 10) break;
                pulseLen++;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic drain(input int n);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (n) @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int pl;
        int k;
        reset = 1'b1; rx_data = '0; rdrf = 1'b0; FE = 1'b0; cfg_we = 1'b0;
        cfg_parity = 2'b00; out_ready = 1'b0; err_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("rst_clr", 32'(rdrf_clr), 0);
        checkOutput("rst_parity", 32'(rx_parity), 0);
        checkOutput("rst_valid", 32'(out_valid), 0);
        checkOutput("rst_count", 32'(fifo_count), 0);
        checkOutput("rst_flags", 32'({overrun, clr_err}), 0);
        checkOutput("rst_fe_count", 32'(fe_count), 0);

        // Single byte
        applyStimulus(8'hA5, 1'b0, 1'b1, 1'b0, pl);
        checkOutput("clr_pulse_len", 32'(pl), 2);
        checkOutput("single_valid", 32'(out_valid), 1);
        checkOutput("single_count", 32'(fifo_count), 1);
        drain(1);
        checkOutput("single_empty", 32'(out_valid), 0);

        // Overrun
        for (int i = 1; i <= 5; i++) applyStimulus(8'(i), 1'b0, i <= 4, 1'b0, pl);
        checkOutput("ovr_count", 32'(fifo_count), 4);
        checkOutput("ovr_flag", 32'(overrun), 1);
        drain(4);
        checkOutput("ovr_drained", 32'(out_valid), 0);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        checkOutput("ovr_cleared", 32'(overrun), 0);

        // Full FIFO with a pop during capture
        applyStimulus(8'h10, 1'b0, 1'b1, 1'b0, pl);
        applyStimulus(8'h20, 1'b0, 1'b1, 1'b0, pl);
        applyStimulus(8'h30, 1'b0, 1'b1, 1'b0, pl);
        applyStimulus(8'h40, 1'b0, 1'b1, 1'b0, pl);
        applyStimulus(8'h55, 1'b0, 1'b1, 1'b1, pl);
        checkOutput("fullpop_overrun", 32'(overrun), 0);
        checkOutput("fullpop_count", 32'(fifo_count), 4);
        drain(4);

        // Framing errors
`ifdef RECEPTOR_CTRL_FE_DROP_EN
        for (int i = 0; i < 3; i++) applyStimulus(8'h81 + 8'(i), 1'b1, 1'b0, 1'b0, pl);
        checkOutput("fe_count", 32'(fe_count), 3);
        checkOutput("fe_fifo_count", 32'(fifo_count), 0);
        checkOutput("fe_overrun", 32'(overrun), 0);
`else
        for (int i = 0; i < 3; i++) applyStimulus(8'h81 + 8'(i), 1'b1, 1'b1, 1'b0, pl);
        checkOutput("fe_count", 32'(fe_count), 3);
        checkOutput("fe_fifo_count", 32'(fifo_count), 3);
        drain(3);
`endif

        // Clear timeout with re-capture of the same byte
        @(posedge clk); #1;
        rx_data = 8'h3C; FE = 1'b0; rdrf = 1'b1;
        expQ.push_back({1'b0, 8'h3C});
        expQ.push_back({1'b0, 8'h3C});
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!clr_err && k < 40);
        checkOutput("timeout_cycles", 32'(k), 19);
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!rdrf_clr && k < 10);
        checkOutput("recapture_clr", 32'(rdrf_clr), 1);
        rdrf = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        checkOutput("timeout_count", 32'(fifo_count), 2);
        checkOutput("timeout_flag", 32'(clr_err), 1);
        drain(2);
        @(posedge clk); #1 err_clr = 1'b1;
        @(posedge clk); #1 err_clr = 1'b0;
        checkOutput("timeout_cleared", 32'(clr_err), 0);

        // Parity deferral
        rx_data = 8'h77; FE = 1'b0; rdrf = 1'b1;
        expQ.push_back({1'b0, 8'h77});
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_parity = 2'b01;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        checkOutput("par_hold_clear", 32'(rx_parity), 0);
        @(posedge clk); #1;
        checkOutput("par_hold_wait", 32'(rx_parity), 0);
        rdrf = 1'b0;
        @(posedge clk); #1;
        checkOutput("par_hold_idle", 32'(rx_parity), 0);
        @(posedge clk); #1;
        checkOutput("par_applied", 32'(rx_parity), 1);

        rx_data = 8'h78; rdrf = 1'b1;
        expQ.push_back({1'b0, 8'h78});
        @(posedge clk); #1;
        @(posedge clk); #1;
        cfg_we = 1'b1; cfg_parity = 2'b10;
        @(posedge clk); #1;
        cfg_parity = 2'b01;
        @(posedge clk); #1;
        cfg_we = 1'b0; rdrf = 1'b0;
        checkOutput("par_busy_hold", 32'(rx_parity), 1);
        repeat (2) @(posedge clk);
        #1;
        checkOutput("par_last_wins", 32'(rx_parity), 1);
        cfg_we = 1'b1; cfg_parity = 2'b10;
        @(posedge clk); #1;
        cfg_we = 1'b0;
        checkOutput("par_idle_direct", 32'(rx_parity), 2);
        drain(2);

        // Reset in the middle of a handshake
        @(posedge clk); #1;
        rx_data = 8'h99; rdrf = 1'b1;
        k = 0;
        do begin
            @(posedge clk); #1;
            k++;
        end while (!rdrf_clr && k < 10);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("midrst_clr", 32'(rdrf_clr), 0);
        checkOutput("midrst_count", 32'(fifo_count), 0);
        checkOutput("midrst_fe_count", 32'(fe_count), 0);
        checkOutput("midrst_parity", 32'(rx_parity), 0);
        rdrf = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        checkOutput("queue_empty", 32'(expQ.size()), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
